// File: rtl/dma_timing_ctrl.sv
// DMA transfer timing FSM: runs the HRQ/HLDA hold handshake for the granted
// channel and sequences address strobes, DACK, bus strobes, count decrement and EOP.
module dma_timing_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CHW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   chGrant,
  input  logic [NUM_CH-1:0]   dreqValid,
  input  logic [7:0]          commandReg,
  input  logic [NUM_CH*8-1:0] modeRegs,
  input  logic                HLDA,
  input  logic                READY,
  input  logic                tc,
  input  logic                EOP_n_in,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic                AEN,
  output logic                ADSTB,
  output logic                MEMR_n,
  output logic                MEMW_n,
  output logic                IOR_n,
  output logic                IOW_n,
  output logic                EOP_n_out,
  output logic                decCount,
  output logic [CHW-1:0]      chSel,
  output logic                busy
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t              r_state, w_nxt;
  logic [1:0]          r_type, r_mode;
  logic                r_eopSeen;
  logic [CHW-1:0]      w_lowIdx, w_sel;
  logic [1:0]          w_grType, w_grMode;
  logic                w_accept, w_endSvc, w_rd, w_wr, w_dackAct;
  logic [NUM_CH-1:0]   w_dackOh;
  logic                w_unused;

  assign w_unused = ^{commandReg, modeRegs};

  // Lowest set grant bit wins; its mode byte is captured on acceptance.
  always_comb begin
    w_lowIdx = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (chGrant[i]) w_lowIdx = CHW'(i);
    w_grType = '0;
    w_grMode = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_lowIdx == CHW'(i)) begin
        w_grType = modeRegs[8*i+2 +: 2];
        w_grMode = modeRegs[8*i+6 +: 2];
      end
  end

  always_comb begin
    w_endSvc = tc | r_eopSeen | ~EOP_n_in;
    w_nxt    = r_state;
    case (r_state)
      SI: if (!commandReg[2] && (|chGrant)) w_nxt = S0;
      S0: if (HLDA) w_nxt = S1;
          else if (!chGrant[chSel]) w_nxt = SI;
      S1: w_nxt = HLDA ? S2 : SI;
      S2: w_nxt = S3;
      S3: if (READY) w_nxt = S4;
      S4: begin
        if (w_endSvc || !HLDA)  w_nxt = SI;
        else if (r_mode == 2'b10) w_nxt = S1;
        else if (r_mode == 2'b00) w_nxt = dreqValid[chSel] ? S1 : SI;
        else                      w_nxt = SI;
      end
      default: w_nxt = SI;
    endcase
    w_accept  = (r_state == SI) && (w_nxt == S0);
    w_sel     = w_accept ? w_lowIdx : chSel;
    w_rd      = (w_nxt == S2) || (w_nxt == S3);
    w_wr      = (w_nxt == S3) || ((w_nxt == S2) && commandReg[5]);
    w_dackAct = (w_nxt == S2) || (w_nxt == S3) || (w_nxt == S4);
    w_dackOh  = NUM_CH'(1) << w_sel;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= SI;
      r_type    <= '0;
      r_mode    <= '0;
      r_eopSeen <= 1'b0;
      HRQ       <= 1'b0;
      AEN       <= 1'b0;
      ADSTB     <= 1'b0;
      decCount  <= 1'b0;
      busy      <= 1'b0;
      chSel     <= '0;
      MEMR_n    <= 1'b1;
      MEMW_n    <= 1'b1;
      IOR_n     <= 1'b1;
      IOW_n     <= 1'b1;
      EOP_n_out <= 1'b1;
      DACK      <= {NUM_CH{commandReg[7]}};
    end else begin
      r_state  <= w_nxt;
      HRQ      <= (w_nxt != SI);
      busy     <= (w_nxt != SI);
      AEN      <= (w_nxt == S1) || w_dackAct;
      ADSTB    <= (w_nxt == S1);
      decCount <= (w_nxt == S4);
      chSel    <= w_sel;
      DACK     <= w_dackAct ? (w_dackOh ^ {NUM_CH{commandReg[7]}}) : {NUM_CH{commandReg[7]}};
      MEMR_n   <= !(w_rd && r_type == 2'b10);
      IOR_n    <= !(w_rd && r_type == 2'b01);
      IOW_n    <= !(w_wr && r_type == 2'b10);
      MEMW_n   <= !(w_wr && r_type == 2'b01);
      // EOP seen only while in S4 is reported in the following cycle.
      EOP_n_out <= !(((w_nxt == S4) && w_endSvc) ||
                     ((r_state == S4) && w_endSvc && EOP_n_out));
      if (((r_state == S2) || (r_state == S3)) && !EOP_n_in) r_eopSeen <= 1'b1;
      else if ((r_state == S4) || (r_state == SI))           r_eopSeen <= 1'b0;
      if (w_accept) begin
        r_type <= w_grType;
        r_mode <= w_grMode;
      end
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Randomized bench: each scenario is expanded into a per-cycle list of expected
// transfer phases and input drives, and the DUT outputs are compared every cycle.
module tb_dma_timing_ctrl;
  localparam int P_SI = 0, P_S0 = 1, P_S1 = 2, P_S2 = 3, P_S3 = 4, P_S4 = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  chGrant, dreqValid;
  logic [7:0]  commandReg;
  logic [31:0] modeRegs;
  logic        HLDA, READY, tc, EOP_n_in;
  logic        HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_n_out, decCount, busy;
  logic [3:0]  DACK;
  logic [1:0]  chSel;

  always #5 clk = ~clk;

  dma_timing_ctrl #(.NUM_CH(4), .CHW(2)) dut (
    .clk(clk), .rst_n(rst_n), .chGrant(chGrant), .dreqValid(dreqValid),
    .commandReg(commandReg), .modeRegs(modeRegs), .HLDA(HLDA), .READY(READY),
    .tc(tc), .EOP_n_in(EOP_n_in), .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
    .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
    .EOP_n_out(EOP_n_out), .decCount(decCount), .chSel(chSel), .busy(busy)
  );

  typedef struct {
    logic [3:0]  grant, dreq;
    logic [7:0]  cmd;
    logic [31:0] modes;
    logic        hlda, ready, tc, eop_n, rst, eopLow;
    int          ph, typ;
    logic [1:0]  sel;
  } cyc_t;

  cyc_t        q[$];
  int          n_vec = 0, n_err = 0, n_cyc = 0;
  logic [1:0]  last_ch = 2'd0;
  logic [7:0]  s_cmd;
  logic [31:0] s_modes;
  logic [3:0]  s_grant, s_oh;
  int          s_typ = 0;
  logic        prev_pol;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_vec(cyc_t c, logic pol);
    logic hrq, rd, wr;
    logic [3:0] oh, dk;
    hrq = (c.ph != P_SI);
    rd  = (c.ph == P_S2) || (c.ph == P_S3);
    wr  = (c.ph == P_S3) || ((c.ph == P_S2) && c.cmd[5]);
    oh  = 4'b0001 << c.sel;
    dk  = (c.ph >= P_S2) ? (pol ? ~oh : oh) : {4{pol}};
    return {hrq, (c.ph >= P_S1), (c.ph == P_S1),
            !(rd && c.typ == 2), !(wr && c.typ == 1), !(rd && c.typ == 1), !(wr && c.typ == 2),
            !c.eopLow, (c.ph == P_S4), hrq, c.sel, dk};
  endfunction

  function automatic cyc_t mk(int ph, logic [1:0] sel);
    cyc_t c;
    c.grant = 4'd0;  c.dreq = 4'd0;  c.cmd = s_cmd;  c.modes = s_modes;
    c.hlda = 1'b0;   c.ready = 1'b1; c.tc = 1'b0;    c.eop_n = 1'b1;
    c.rst = 1'b0;    c.eopLow = 1'b0; c.ph = ph;     c.typ = s_typ; c.sel = sel;
    return c;
  endfunction

  function automatic logic [3:0] rnd_dreq(logic b);
    return (4'($urandom) & ~s_oh) | (b ? s_oh : 4'd0);
  endfunction

  task automatic setup(input int ch, input int typ, input int mode, input int ext, input int pol);
    logic [3:0] hi;
    s_cmd    = 8'($urandom);
    s_cmd[7] = pol[0];
    s_cmd[5] = ext[0];
    s_cmd[2] = 1'b0;
    s_modes  = $urandom;
    s_modes[8*ch+2 +: 2] = 2'(typ);
    s_modes[8*ch+6 +: 2] = 2'(mode);
    s_oh     = 4'b0001 << ch;
    hi       = 4'b1110 << ch;
    s_grant  = (4'($urandom) & hi) | s_oh;
    s_typ    = typ;
  endtask

  // endk: 0 natural end (single / demand DREQ drop), 1 tc, 2 EOP in S2, 3 HLDA drop in S4
  task automatic build_xfer(input int ch, input int typ, input int mode, input int ext, input int pol,
                            input int d, input int n, input int endk, input int wfix);
    cyc_t c;
    bit   last;
    int   w;
    setup(ch, typ, mode, ext, pol);
    if (mode == 1 || mode == 3) n = 1;
    c = mk(P_SI, last_ch); c.grant = s_grant; c.dreq = rnd_dreq(1); q.push_back(c);
    for (int j = 0; j <= d; j++) begin
      c = mk(P_S0, 2'(ch)); c.grant = s_grant; c.hlda = (j == d); c.dreq = rnd_dreq(1); q.push_back(c);
    end
    for (int t = 0; t < n; t++) begin
      last = (t == n-1);
      w = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
      c = mk(P_S1, 2'(ch)); c.grant = s_grant; c.hlda = 1; c.dreq = rnd_dreq(1); q.push_back(c);
      c = mk(P_S2, 2'(ch)); c.grant = s_grant; c.hlda = 1; c.dreq = rnd_dreq(1);
      c.eop_n = !(last && endk == 2); q.push_back(c);
      for (int k = 0; k <= w; k++) begin
        c = mk(P_S3, 2'(ch)); c.grant = s_grant; c.hlda = 1; c.dreq = rnd_dreq(1);
        c.ready = (k == w); c.tc = last && endk == 1; q.push_back(c);
      end
      c = mk(P_S4, 2'(ch)); c.grant = last ? 4'd0 : s_grant; c.hlda = !(last && endk == 3);
      c.tc = last && endk == 1; c.dreq = rnd_dreq(!(last && endk == 0));
      c.eopLow = last && (endk == 1 || endk == 2); q.push_back(c);
    end
    c = mk(P_SI, 2'(ch)); q.push_back(c);
    last_ch = 2'(ch);
  endtask

  task automatic build_abort(input int ch);
    cyc_t c;
    setup(ch, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 1)));
    c = mk(P_SI, last_ch); c.grant = s_grant; q.push_back(c);
    c = mk(P_S0, 2'(ch)); c.grant = s_grant; q.push_back(c);
    c = mk(P_S0, 2'(ch)); c.grant = s_grant & ~s_oh; q.push_back(c);
    c = mk(P_SI, 2'(ch)); q.push_back(c);
    last_ch = 2'(ch);
  endtask

  task automatic build_disabled(input int ch);
    cyc_t c;
    setup(ch, 2, 1, 0, int'($urandom_range(0, 1)));
    s_cmd[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      c = mk(P_SI, last_ch); c.grant = s_grant; c.hlda = 1; q.push_back(c);
    end
    s_cmd[2] = 1'b0;
    c = mk(P_SI, last_ch); q.push_back(c);
  endtask

  task automatic build_rst(input int ch);
    cyc_t c;
    setup(ch, 2, 1, 0, int'($urandom_range(0, 1)));
    c = mk(P_SI, last_ch); c.grant = s_grant; q.push_back(c);
    c = mk(P_S0, 2'(ch)); c.grant = s_grant; c.hlda = 1; q.push_back(c);
    c = mk(P_S1, 2'(ch)); c.grant = s_grant; c.hlda = 1; q.push_back(c);
    c = mk(P_S2, 2'(ch)); c.grant = s_grant; c.hlda = 1; q.push_back(c);
    c = mk(P_S3, 2'(ch)); c.grant = s_grant; c.hlda = 1; c.ready = 0; c.rst = 1; q.push_back(c);
    c = mk(P_SI, 2'd0); q.push_back(c);
    c = mk(P_SI, 2'd0); q.push_back(c);
    last_ch = 2'd0;
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      n_cyc++;
      chk($sformatf("cyc%0d_ph%0d", n_cyc, c.ph),
          {HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_n_out, decCount, busy, chSel, DACK},
          exp_vec(c, prev_pol));
      chGrant = c.grant; dreqValid = c.dreq; commandReg = c.cmd; modeRegs = c.modes;
      HLDA = c.hlda; READY = c.ready; tc = c.tc; EOP_n_in = c.eop_n; rst_n = !c.rst;
      prev_pol = c.cmd[7];
    end
  endtask

  initial begin
    int kind, mode, endk;
    rst_n = 1'b0; chGrant = 4'd0; dreqValid = 4'd0; HLDA = 1'b0; READY = 1'b1;
    tc = 1'b0; EOP_n_in = 1'b1; modeRegs = $urandom;
    commandReg = 8'($urandom);
    s_cmd = commandReg; s_modes = modeRegs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_n_out, decCount, busy, chSel, DACK},
        exp_vec(mk(P_SI, 2'd0), commandReg[7]));
    rst_n = 1'b1; commandReg[2] = 1'b0; prev_pol = commandReg[7];

    build_xfer(1, 2, 1, 0, 0, 2, 1, 0, 0);  run_q();  // ch1 single read, HLDA after 2
    build_xfer(2, 1, 2, 0, 0, 0, 3, 1, 0);  run_q();  // ch2 block write, tc on 3rd
    build_xfer(0, 2, 0, 0, 0, 1, 2, 0, 0);  run_q();  // ch0 demand, DREQ drop on 2nd
    build_xfer(1, 2, 1, 0, 0, 0, 1, 0, 3);  run_q();  // 3 wait states
    build_xfer(3, 2, 1, 1, 1, 1, 1, 0, 0);  run_q();  // active-low DACK, extended write
    build_disabled(2);                      run_q();
    build_rst(1);                           run_q();
    build_xfer(2, 2, 2, 0, 0, 0, 2, 2, 0);  run_q();  // EOP in S2 of block
    build_abort(3);                         run_q();

    for (int s = 0; s < 60; s++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      build_abort(int'($urandom_range(0, 3)));
      else if (kind == 1) build_rst(int'($urandom_range(0, 3)));
      else if (kind == 2) build_disabled(int'($urandom_range(0, 3)));
      else begin
        mode = int'($urandom_range(0, 3));
        endk = (mode == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        build_xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), mode,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), endk, -1);
      end
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- DMA transfer timing/control FSM; the consuming end of the channel priority logic.
- Takes the one-hot serviced-channel grant, runs the HRQ/HLDA hold handshake with the CPU, drives DACK, AEN/ADSTB and the memory/IO strobes, and signals per-transfer count decrement and end-of-process.
- Sits between the priority encoder and the address/count register block.

Parameters:
- NUM_CH, 4, number of DMA channels (only 4 is supported).
- CHW, 2, width of the channel index.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- chGrant  in  NUM_CH  one-hot serviced channel from priority logic (0 = none)
- dreqValid  in  NUM_CH  per-channel polarity-corrected, unmasked DREQ
- commandReg  in  8  bit2 controller disable, bit5 extended write, bit7 DACK sense (0 = active-high, 1 = active-low)
- modeRegs  in  4*8  mode register of channel n at [8n+7:8n]; [3:2] type (00 verify, 01 write, 10 read), [7:6] mode (00 demand, 01 single, 10 block)
- HLDA  in  1  hold acknowledge from CPU
- READY  in  1  0 inserts wait states
- tc  in  1  terminal count reached on current transfer (from count block)
- EOP_n_in  in  1  external end-of-process, active-low
- HRQ  out  1  hold request
- DACK  out  NUM_CH  DMA acknowledge, polarity per commandReg[7]
- AEN  out  1  address enable
- ADSTB  out  1  address strobe
- MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  bus strobes, active-low
- EOP_n_out  out  1  end-of-process, active-low
- decCount  out  1  one-cycle pulse: advance address/count of chSel
- chSel  out  CHW  index of channel in service
- busy  out  1  high in any state other than SI

Behaviour:
- All outputs are registered; state changes take effect at the next clk edge.
- Reset (rst_n = 0 at an edge) is honoured in any state. Reset values:
  - state = SI; HRQ, AEN, ADSTB, decCount, busy, chSel = 0.
  - All strobes and EOP_n_out = 1.
  - DACK = all inactive: 4'b0000 when commandReg[7] = 0, 4'b1111 when 1.
- States: SI, S0, S1, S2, S3, S4.
- SI:
  - If commandReg[2] = 0 and chGrant != 0: latch chSel = index of the lowest set bit, latch that channel's mode, go to S0.
  - Otherwise stay in SI.
- S0:
  - HRQ = 1.
  - If HLDA = 1, go to S1.
  - If chGrant[chSel] = 0 before HLDA arrives, go to SI and drop HRQ.
- S1:
  - AEN = 1, ADSTB = 1 for this one cycle.
  - Go to S2. If HLDA = 0 here, go to SI.
- S2:
  - AEN = 1; DACK[chSel] active.
  - Read strobe: type read -> MEMR_n = 0; type write -> IOR_n = 0; verify -> none.
  - If extended write (commandReg[5] = 1), also assert the write strobe here.
  - Go to S3.
- S3:
  - Read strobe stays asserted.
  - Write strobe: type read -> IOW_n = 0; type write -> MEMW_n = 0.
  - Stay in S3 while READY = 0 (one wait state per cycle); go to S4 when READY = 1.
- S4:
  - All strobes deasserted; DACK stays active; decCount = 1 for this one cycle.
- S4 exit: endSvc = tc, or EOP_n_in sampled 0 in S2/S3/S4.
  - If endSvc: EOP_n_out = 0 for this cycle, go to SI.
  - Else if HLDA = 0: go to SI.
  - Else single mode: go to SI.
  - Else block mode: go to S1.
  - Else demand mode: go to S1 if dreqValid[chSel] = 1, otherwise SI.
- Whenever S4 exits to SI:
  - HRQ, AEN and DACK go inactive in SI.
  - HRQ stays low for at least one SI cycle before the next request is accepted.
- Once latched, chSel does not change until the return to SI.
- Mode 11 (cascade) is treated as single.
- A commandReg[2] change mid-transfer takes effect only in SI.

Test Plan:
- Ch1 read, single mode, HLDA 2 cycles after HRQ, READY = 1 -> sequence S0,S0,S0,S1,S2,S3,S4,SI; MEMR_n low in S2–S3, IOW_n low in S3 only; DACK[1] high S2–S4; one decCount pulse; HRQ low in SI.
- Ch2 block write, tc asserted on the 3rd transfer -> three S1–S4 loops, three decCount pulses, EOP_n_out low in the final S4, then SI.
- Ch0 demand read; dreqValid[0] drops during the 2nd transfer -> exactly two transfers, then SI.
- READY held low 3 cycles in S3 -> S3 occupies 4 cycles, strobes stay asserted, exactly one decCount.
- commandReg[7] = 1 with ch3 granted -> DACK = 4'b0111 in S2–S4, 4'b1111 otherwise.
- commandReg[2] = 1 with a grant -> stays in SI, HRQ = 0.
- Reset asserted in S3 -> next edge: SI and all reset values.
- EOP_n_in pulsed low in S2 of a block transfer -> EOP_n_out low in that S4, return to SI.
